// File: rtl/display_scheduler_pkg.sv
// Shared types and helpers for the display scheduler: state encoding,
// the "no source" code and the ascending/wrapping next-valid-source search.
package display_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_ALERT = 2'd2
    } state_e;

    localparam logic [1:0] SRC_NONE = 2'd3;

    function automatic int unsigned ms_div(input int unsigned clk_hz);
        return clk_hz / 1000;
    endfunction

    function automatic logic [1:0] wrap_inc(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Searches ptr+1, ptr+2, then ptr itself, so a lone valid source re-selects itself
    function automatic logic [1:0] next_idx(input logic [1:0] ptr, input logic [2:0] vld);
        logic [1:0] c1;
        logic [1:0] c2;
        logic [1:0] c3;
        c1 = wrap_inc(ptr);
        c2 = wrap_inc(c1);
        c3 = wrap_inc(c2);
        if (vld[c1]) return c1;
        if (vld[c2]) return c2;
        return c3;
    endfunction

endpackage

// File: rtl/display_scheduler_ms_tick_gen.sv
// Free-running millisecond strobe: one-clock pulse every CLK_HZ/1000 clocks.
module ms_tick_gen
    import display_scheduler_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic ms_tick
);

    localparam int unsigned DIV = ms_div(CLK_HZ);

    logic [31:0] cnt_q, cnt_d;
    logic        tick_q, tick_d;

    always_comb begin
        tick_d = (cnt_q == 32'(DIV - 1));
        cnt_d  = tick_d ? 32'd0 : cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 32'd0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign ms_tick = tick_q;

endmodule

// File: rtl/display_scheduler.sv
// Time-shares one 4-digit display between three sources with a fixed dwell;
// a rising alert request preempts the rotation and shows a blinking value.
module display_scheduler
    import display_scheduler_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned DWELL_MS = 2000,
    parameter int unsigned ALERT_MS = 3000,
    parameter int unsigned BLINK_MS = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] src_val0,
    input  logic [7:0] src_val1,
    input  logic [7:0] src_val2,
    input  logic [2:0] src_vld,
    input  logic       alert_req,
    input  logic [7:0] alert_val,
    output logic       alert_ack,
    output logic [7:0] disp_val,
    output logic [1:0] disp_src,
    output logic       disp_blank,
    output logic       alert_busy
);

    localparam int unsigned TMR_MAX = (DWELL_MS > ALERT_MS) ? DWELL_MS : ALERT_MS;
    localparam int unsigned TW      = $clog2(TMR_MAX + 1);
    localparam int unsigned BW      = $clog2(BLINK_MS + 1);

    logic ms_tick;

    ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_ms_tick_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .ms_tick (ms_tick)
    );

    state_e        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    resume_q, resume_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_ph_q, blink_ph_d;
    logic [7:0]    alert_val_q, alert_val_d;
    logic          req_prev_q, req_prev_d;
    logic          ack_q, ack_d;
    logic [7:0]    disp_val_q, disp_val_d;
    logic [1:0]    disp_src_q, disp_src_d;
    logic          blank_q, blank_d;
    logic          busy_q, busy_d;
    logic          accept;
    logic [7:0]    sel_val;

    always_comb begin
        case (ptr_q)
            2'd0:    sel_val = src_val0;
            2'd1:    sel_val = src_val1;
            default: sel_val = src_val2;
        endcase
    end

    // Next state: alert acceptance outranks source changes and dwell expiry
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        resume_d    = resume_q;
        tmr_d       = tmr_q;
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        alert_val_d = alert_val_q;
        req_prev_d  = alert_req;
        accept      = alert_req && !req_prev_q;

        if (accept) begin
            state_d     = ST_ALERT;
            alert_val_d = alert_val;
            tmr_d       = '0;
            blink_cnt_d = '0;
            blink_ph_d  = 1'b0;
            resume_d    = next_idx(ptr_q, src_vld);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tmr_d = '0;
                    if (src_vld != 3'b000) begin
                        state_d = ST_SHOW;
                        ptr_d   = next_idx(2'd2, src_vld);
                    end
                end
                ST_SHOW: begin
                    if (src_vld == 3'b000) begin
                        state_d = ST_IDLE;
                        tmr_d   = '0;
                    end else if (!src_vld[ptr_q]) begin
                        ptr_d = next_idx(ptr_q, src_vld);
                        tmr_d = '0;
                    end else if (ms_tick) begin
                        if (tmr_q == TW'(DWELL_MS - 1)) begin
                            ptr_d = next_idx(ptr_q, src_vld);
                            tmr_d = '0;
                        end else begin
                            tmr_d = tmr_q + TW'(1);
                        end
                    end
                end
                ST_ALERT: begin
                    if (ms_tick) begin
                        if (tmr_q == TW'(ALERT_MS - 1)) begin
                            tmr_d = '0;
                            if (src_vld[resume_q]) begin
                                state_d = ST_SHOW;
                                ptr_d   = resume_q;
                            end else if (src_vld != 3'b000) begin
                                state_d = ST_SHOW;
                                ptr_d   = next_idx(resume_q, src_vld);
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            tmr_d = tmr_q + TW'(1);
                            if (blink_cnt_q == BW'(BLINK_MS - 1)) begin
                                blink_cnt_d = '0;
                                blink_ph_d  = !blink_ph_q;
                            end else begin
                                blink_cnt_d = blink_cnt_q + BW'(1);
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Registered outputs follow the current state one clock later
    always_comb begin
        ack_d      = accept;
        busy_d     = (state_q == ST_ALERT);
        disp_src_d = SRC_NONE;
        disp_val_d = 8'd0;
        blank_d    = 1'b1;
        case (state_q)
            ST_SHOW: begin
                disp_src_d = ptr_q;
                disp_val_d = sel_val;
                blank_d    = 1'b0;
            end
            ST_ALERT: begin
                disp_val_d = alert_val_q;
                blank_d    = blink_ph_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 2'd0;
            resume_q    <= 2'd0;
            tmr_q       <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            alert_val_q <= 8'd0;
            req_prev_q  <= 1'b0;
            ack_q       <= 1'b0;
            disp_val_q  <= 8'd0;
            disp_src_q  <= SRC_NONE;
            blank_q     <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            resume_q    <= resume_d;
            tmr_q       <= tmr_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            alert_val_q <= alert_val_d;
            req_prev_q  <= req_prev_d;
            ack_q       <= ack_d;
            disp_val_q  <= disp_val_d;
            disp_src_q  <= disp_src_d;
            blank_q     <= blank_d;
            busy_q      <= busy_d;
        end
    end

    assign alert_ack  = ack_q;
    assign disp_val   = disp_val_q;
    assign disp_src   = disp_src_q;
    assign disp_blank = blank_q;
    assign alert_busy = busy_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with a 4-clock millisecond so dwell,
// blink and alert timing can be checked in clock counts.
module tb_display_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] src_val0, src_val1, src_val2;
    logic [2:0] src_vld;
    logic       alert_req;
    logic [7:0] alert_val;
    logic       alert_ack;
    logic [7:0] disp_val;
    logic [1:0] disp_src;
    logic       disp_blank;
    logic       alert_busy;

    int n_checks = 0;
    int n_errors = 0;

    display_scheduler #(
        .CLK_HZ   (4000),
        .DWELL_MS (4),
        .ALERT_MS (6),
        .BLINK_MS (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_val0   (src_val0),
        .src_val1   (src_val1),
        .src_val2   (src_val2),
        .src_vld    (src_vld),
        .alert_req  (alert_req),
        .alert_val  (alert_val),
        .alert_ack  (alert_ack),
        .disp_val   (disp_val),
        .disp_src   (disp_src),
        .disp_blank (disp_blank),
        .alert_busy (alert_busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Steps until disp_src changes; n = clocks stepped
    task automatic wait_switch(output int n);
        logic [1:0] cur;
        cur = disp_src;
        n = 0;
        do begin
            tick();
            n++;
        end while (disp_src == cur && n < 64);
        if (n >= 64) check_eq("switch_timeout", 32'(n), 32'd0);
    endtask

    task automatic wait_busy_low();
        int n;
        n = 0;
        while (alert_busy && n < 64) begin
            tick();
            n++;
        end
        if (n >= 64) check_eq("busy_timeout", 32'(n), 32'd0);
    endtask

    int n;
    int acks, busy_n, run_cnt, run_len, bad_val;
    int runs[4];
    int run_lvl[4];
    logic prev_busy, prev_blank;
    logic [1:0] src_after;

    initial begin
        rst_n     = 1'b0;
        src_val0  = 8'd10;
        src_val1  = 8'd20;
        src_val2  = 8'd30;
        src_vld   = 3'b000;
        alert_req = 1'b0;
        alert_val = 8'd0;

        // Reset and idle
        ticks(3);
        check_eq("rst_blank", 32'(disp_blank), 32'd1);
        check_eq("rst_val", 32'(disp_val), 32'd0);
        check_eq("rst_src", 32'(disp_src), 32'd3);
        check_eq("rst_ack", 32'(alert_ack), 32'd0);
        check_eq("rst_busy", 32'(alert_busy), 32'd0);
        rst_n = 1'b1;
        ticks(6);
        check_eq("idle_blank", 32'(disp_blank), 32'd1);
        check_eq("idle_src", 32'(disp_src), 32'd3);

        // Rotation over sources 0 and 2, 16 clocks each
        src_vld = 3'b101;
        wait_switch(n);
        check_eq("first_src", 32'(disp_src), 32'd0);
        check_eq("show_blank", 32'(disp_blank), 32'd0);
        wait_switch(n);
        check_eq("rot_src_a", 32'(disp_src), 32'd2);
        tick();
        check_eq("rot_val_a", 32'(disp_val), 32'd30);
        wait_switch(n);
        check_eq("rot_src_b", 32'(disp_src), 32'd0);
        check_eq("rot_hold_b", 32'(n + 1), 32'd16);
        tick();
        check_eq("rot_val_b", 32'(disp_val), 32'd10);
        wait_switch(n);
        check_eq("rot_src_c", 32'(disp_src), 32'd2);
        check_eq("rot_hold_c", 32'(n + 1), 32'd16);
        tick();
        check_eq("rot_val_c", 32'(disp_val), 32'd30);
        wait_switch(n);
        check_eq("rot_src_d", 32'(disp_src), 32'd0);
        check_eq("rot_hold_d", 32'(n + 1), 32'd16);

        // Drop the shown source, then all sources
        src_vld = 3'b100;
        ticks(2);
        check_eq("drop_src", 32'(disp_src), 32'd2);
        check_eq("drop_val", 32'(disp_val), 32'd30);
        src_vld = 3'b000;
        ticks(2);
        check_eq("none_blank", 32'(disp_blank), 32'd1);
        check_eq("none_src", 32'(disp_src), 32'd3);
        check_eq("none_val", 32'(disp_val), 32'd0);

        // Held alert request during SHOW(0) with all sources valid
        src_vld = 3'b111;
        ticks(3);
        check_eq("pre_alert_src", 32'(disp_src), 32'd0);
        alert_val = 8'd99;
        alert_req = 1'b1;
        acks = 0; busy_n = 0; run_cnt = 0; run_len = 0; bad_val = 0;
        prev_busy = 1'b0; prev_blank = 1'b0; src_after = 2'd0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (i == 49) alert_req = 1'b0;
            if (alert_ack) acks++;
            if (alert_busy) begin
                busy_n++;
                if (disp_val != 8'd99) bad_val++;
                if (!prev_busy || disp_blank != prev_blank) begin
                    if (run_cnt < 4) begin
                        run_lvl[run_cnt] = int'(disp_blank);
                        runs[run_cnt] = 0;
                    end
                    run_cnt++;
                end
                if (run_cnt <= 4) runs[run_cnt-1]++;
                prev_blank = disp_blank;
            end else if (prev_busy) begin
                src_after = disp_src;
            end
            prev_busy = alert_busy;
        end
        check_eq("hold_acks", 32'(acks), 32'd1);
        check_eq("hold_val99", 32'(bad_val), 32'd0);
        check_eq("hold_busy_len", 32'(busy_n >= 21 && busy_n <= 24), 32'd1);
        check_eq("blink_runs", 32'(run_cnt), 32'd3);
        if (run_cnt == 3) begin
            check_eq("blink_lvl0", 32'(run_lvl[0]), 32'd0);
            check_eq("blink_lvl1", 32'(run_lvl[1]), 32'd1);
            check_eq("blink_lvl2", 32'(run_lvl[2]), 32'd0);
            check_eq("blink_run1", 32'(runs[1]), 32'd8);
            check_eq("blink_run2", 32'(runs[2]), 32'd8);
        end
        check_eq("resume_src", 32'(src_after), 32'd1);

        // Alert accepted on the dwell-expiry clock
        src_vld = 3'b101;
        wait_switch(n);
        wait_switch(n);
        ticks(14);
        alert_val = 8'd55;
        alert_req = 1'b1;
        ticks(2);
        alert_req = 1'b0;
        check_eq("coinc_src", 32'(disp_src), 32'd3);
        check_eq("coinc_busy", 32'(alert_busy), 32'd1);
        check_eq("coinc_val", 32'(disp_val), 32'd55);
        wait_busy_low();
        check_eq("coinc_resume", 32'(disp_src), 32'd2);

        // Re-triggered alert restarts the alert duration
        alert_val = 8'd42;
        alert_req = 1'b1;
        tick();
        alert_req = 1'b0;
        ticks(12);
        check_eq("retrig_busy", 32'(alert_busy), 32'd1);
        alert_val = 8'd7;
        alert_req = 1'b1;
        tick();
        alert_req = 1'b0;
        check_eq("retrig_ack", 32'(alert_ack), 32'd1);
        busy_n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!alert_busy) break;
            if (busy_n == 0) check_eq("retrig_val", 32'(disp_val), 32'd7);
            busy_n++;
        end
        check_eq("retrig_len", 32'(busy_n >= 21 && busy_n <= 24), 32'd1);

        // Asynchronous reset while showing a source
        src_vld = 3'b111;
        ticks(8);
        check_eq("pre_rst_blank", 32'(disp_blank), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_blank", 32'(disp_blank), 32'd1);
        check_eq("mid_rst_val", 32'(disp_val), 32'd0);
        check_eq("mid_rst_src", 32'(disp_src), 32'd3);
        check_eq("mid_rst_ack", 32'(alert_ack), 32'd0);
        ticks(2);
        rst_n = 1'b1;
        ticks(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
